y86_seq_controller: RTL

Multi-cycle sequencer for the Y86-64 sequential datapath (fetch, decode, execute, memory, write_back, pc_update). Walks one instruction at a time through the stages. Issues per-stage enables and the architectural write strobes (PC, register file, condition codes). Owns the data-memory request/acknowledge handshake and the processor status code (AOK/HLT/ADR/INS), replacing free-running clock-edge sequencing with an explicit, stallable FSM.

---
 rtl/y86_pkg.sv | 48 ++++
 rtl/y86_seq_controller_if.sv | 42 ++++
 rtl/y86_mem_wait_timer.sv | 40 ++++
 rtl/y86_seq_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 sequential controller: instruction codes,
// status codes, state encoding and instruction-class predicates.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 4'd4;

  // PAUSE sits outside the 3-bit stage space; it only exists with single-step.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_MEMORY    = 4'd4,
    S_WRITEBACK = 4'd5,
    S_PCUPD     = 4'd6,
    S_STOP      = 4'd7,
    S_PAUSE     = 4'd8
  } state_e;

  function automatic logic is_mem_op(input logic [3:0] ic);
    return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  endfunction

  function automatic logic is_mem_wr(input logic [3:0] ic);
    return ic inside {I_RMMOVQ, I_CALL, I_PUSHQ};
  endfunction

  function automatic logic writes_rf(input logic [3:0] ic);
    return ic inside {I_IRMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  endfunction

endpackage

// File: rtl/y86_seq_controller_if.sv
// Controller <-> datapath bundle. Optional single-step input is present only
// when Y86_SINGLE_STEP_EN is defined.
interface y86_seq_controller_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [3:0]       icode;
  logic             cnd;
  logic             instr_err;
  logic             imem_error;
  logic             dmem_ack;
  logic             dmem_error;
`ifdef Y86_SINGLE_STEP_EN
  logic             step;
`endif
  logic [2:0]       stage;
  logic             pc_we;
  logic             rf_we;
  logic             cc_we;
  logic             dmem_req;
  logic             dmem_wr;
  logic [2:0]       stat;
  logic             busy;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  start, icode, cnd, instr_err, imem_error, dmem_ack, dmem_error,
`ifdef Y86_SINGLE_STEP_EN
    input  step,
`endif
    output stage, pc_we, rf_we, cc_we, dmem_req, dmem_wr, stat, busy, instr_cnt
  );

  modport slave (
    output start, icode, cnd, instr_err, imem_error, dmem_ack, dmem_error,
`ifdef Y86_SINGLE_STEP_EN
    output step,
`endif
    input  stage, pc_we, rf_we, cc_we, dmem_req, dmem_wr, stat, busy, instr_cnt
  );

endinterface

// File: rtl/y86_mem_wait_timer.sv
// Counts cycles spent waiting for a data-memory acknowledge; expired_o is high
// during the MEM_TIMEOUT-th enabled cycle after a clear.
module y86_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired_o = (cnt_q == W'(MEM_TIMEOUT - 1));

  // Saturate once expired so a late ack cannot wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/y86_seq_controller.sv
// Multi-cycle Y86-64 sequencer: stage walk, write strobes, dmem handshake and
// status. Define Y86_SINGLE_STEP_EN to add the step input and PAUSE state.
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  y86_seq_controller_if.master  bus
);

  state_e           state_q, state_d;
  logic [3:0]       icode_q, icode_d;
  logic             cnd_q, cnd_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_mem_s;
  logic timer_expired_s;
  logic pc_we_s, rf_we_s, cc_we_s, req_s, wr_s;

  assign in_mem_s = (state_q == S_MEMORY);

  y86_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (!in_mem_s),
    .enable_i  (in_mem_s),
    .expired_o (timer_expired_s)
  );

  // State, latched instruction context, status and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      icode_q <= I_HALT;
      cnd_q   <= 1'b0;
      stat_q  <= STAT_AOK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and context update.
  always_comb begin
    state_d = state_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        icode_d = bus.icode;
        if (bus.imem_error) begin
          state_d = S_STOP;
          stat_d  = STAT_ADR;
        end else if (bus.instr_err) begin
          state_d = S_STOP;
          stat_d  = STAT_INS;
        end else if (bus.icode == I_HALT) begin
          state_d = S_STOP;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        cnd_d = bus.cnd;
        if (is_mem_op(icode_q)) begin
          state_d = S_MEMORY;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        // An ack arriving in the expiry cycle still completes the access.
        if (bus.dmem_ack) begin
          if (bus.dmem_error) begin
            state_d = S_STOP;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (timer_expired_s) begin
          state_d = S_STOP;
          stat_d  = STAT_ADR;
        end else begin
          state_d = S_MEMORY;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef Y86_SINGLE_STEP_EN
        state_d = S_PAUSE;
`else
        state_d = S_FETCH;
`endif
      end
`ifdef Y86_SINGLE_STEP_EN
      S_PAUSE: begin
        if (bus.step) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_PAUSE;
        end
      end
`endif
      S_STOP:  state_d = S_STOP;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore strobe decode from registered state and latched icode/cnd.
  always_comb begin
    pc_we_s = 1'b0;
    rf_we_s = 1'b0;
    cc_we_s = 1'b0;
    req_s   = 1'b0;
    wr_s    = 1'b0;
    case (state_q)
      S_EXECUTE:   cc_we_s = (icode_q == I_OPQ);
      S_MEMORY: begin
        req_s = 1'b1;
        wr_s  = is_mem_wr(icode_q);
      end
      S_WRITEBACK: rf_we_s = writes_rf(icode_q) || ((icode_q == I_RRMOVQ) && cnd_q);
      S_PCUPD:     pc_we_s = 1'b1;
      default:     ;
    endcase
  end

  // PAUSE reports as PCUPD: the last stage that completed.
  assign bus.stage     = (state_q == S_PAUSE) ? S_PCUPD[2:0] : state_q[2:0];
  assign bus.pc_we     = pc_we_s;
  assign bus.rf_we     = rf_we_s;
  assign bus.cc_we     = cc_we_s;
  assign bus.dmem_req  = req_s;
  assign bus.dmem_wr   = wr_s;
  assign bus.stat      = stat_q;
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_STOP);
  assign bus.instr_cnt = cnt_q;

endmodule
